// File: rtl/way_hit_detect_pkg.sv
// Shared constants, types and tree pseudo-LRU helpers for the way hit-detect slice.
// WAY_HIT_PLRU_EN selects per-set tree PLRU; otherwise a global round-robin victim counter is used.
package cache_pkg;

    localparam int WAYS     = 4;
    localparam int SETS     = 64;
    localparam int TAG_BITS = 20;
    localparam int SET_BITS = $clog2(SETS);
    localparam int LVLS     = $clog2(WAYS);
    localparam int NODES    = WAYS - 1;

    typedef logic [WAYS-1:0]  way_onehot_t;
    typedef logic [NODES-1:0] plru_bits_t;
    // NODES < WAYS, so LVLS bits are enough to address every tree node.
    typedef logic [LVLS-1:0]  node_idx_t;

    function automatic way_onehot_t lowest_set(way_onehot_t v);
        return v & (~v + way_onehot_t'(1));
    endfunction

    function automatic int onehot_idx(way_onehot_t oh);
        int idx;
        idx = 0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

    // Walk from the root; a 0 bit steers toward the lower-index half.
    function automatic way_onehot_t plru_victim(plru_bits_t bits);
        int node;
        int leaf;
        int b;
        node = 0;
        leaf = 0;
        for (int l = 0; l < LVLS; l++) begin
            b    = bits[node_idx_t'(node)] ? 1 : 0;
            leaf = 2 * leaf + b;
            node = 2 * node + 1 + b;
        end
        return way_onehot_t'(1) << leaf;
    endfunction

    // Every node on the path of the touched way is turned to point away from it.
    function automatic plru_bits_t plru_touch(plru_bits_t bits, way_onehot_t way);
        plru_bits_t nb;
        int         node;
        int         w;
        int         dir;
        nb   = bits;
        node = 0;
        w    = onehot_idx(way);
        for (int l = 0; l < LVLS; l++) begin
            dir                     = (w >> (LVLS - 1 - l)) & 1;
            nb[node_idx_t'(node)]   = (dir == 0);
            node                    = 2 * node + 1 + dir;
        end
        return nb;
    endfunction

endpackage

// File: rtl/way_hit_detect_if.sv
// Request/response/fill bundle between the tag-array front end and the hit-detect stage.
interface way_hit_detect_if;
    import cache_pkg::*;

    logic                     i_req_valid;
    logic                     o_req_ready;
    logic [TAG_BITS-1:0]      i_req_tag;
    logic [SET_BITS-1:0]      i_req_set;
    logic [WAYS*TAG_BITS-1:0] i_tags;
    way_onehot_t              i_way_valid;

    logic                     o_rsp_valid;
    logic                     i_rsp_ready;
    logic                     o_hit;
    way_onehot_t              o_way_sel;
    way_onehot_t              o_victim_way;
    logic                     o_multi_hit;

    logic                     i_fill_valid;
    logic [SET_BITS-1:0]      i_fill_set;
    way_onehot_t              i_fill_way;

    modport master (
        output i_req_valid, i_req_tag, i_req_set, i_tags, i_way_valid,
        output i_rsp_ready, i_fill_valid, i_fill_set, i_fill_way,
        input  o_req_ready, o_rsp_valid, o_hit, o_way_sel, o_victim_way, o_multi_hit
    );

    modport slave (
        input  i_req_valid, i_req_tag, i_req_set, i_tags, i_way_valid,
        input  i_rsp_ready, i_fill_valid, i_fill_set, i_fill_way,
        output o_req_ready, o_rsp_valid, o_hit, o_way_sel, o_victim_way, o_multi_hit
    );

endinterface

// File: rtl/way_hit_detect_plru_tree.sv
// Per-set tree pseudo-LRU state with a combinational victim read and hit/fill touch ports.
// Used by way_hit_detect only when WAY_HIT_PLRU_EN is defined.
module plru_tree
    import cache_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [SET_BITS-1:0] rd_set,
    output way_onehot_t         rd_victim,
    input  logic                hit_en,
    input  logic [SET_BITS-1:0] hit_set,
    input  way_onehot_t         hit_way,
    input  logic                fill_en,
    input  logic [SET_BITS-1:0] fill_set,
    input  way_onehot_t         fill_way
);

    logic [SETS-1:0][NODES-1:0] set_bits;
    logic                       fill_ok;

    // A fill whose way vector is not one-hot carries no usable way and is dropped.
    assign fill_ok = fill_en && (fill_way != '0)
                     && ((fill_way & (fill_way - way_onehot_t'(1))) == '0);

    assign rd_victim = plru_victim(set_bits[rd_set]);

    for (genvar gi = 0; gi < SETS; gi++) begin : g_set
        plru_bits_t bits_reg;

        // Fill wins over a hit in the same set; different sets update independently.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                bits_reg <= '0;
            end else if (fill_ok && (fill_set == SET_BITS'(gi))) begin
                bits_reg <= plru_touch(bits_reg, fill_way);
            end else if (hit_en && (hit_set == SET_BITS'(gi))) begin
                bits_reg <= plru_touch(bits_reg, hit_way);
            end
        end

        assign set_bits[gi] = bits_reg;
    end

endmodule

// File: rtl/way_hit_detect.sv
// 4-way tag compare with registered one-hot way select, hit/multi-hit flags and victim choice.
// WAY_HIT_PLRU_EN: per-set tree PLRU victim; undefined: global round-robin victim counter.
module way_hit_detect
    import cache_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    way_hit_detect_if.slave bus
);

    way_onehot_t match;
    way_onehot_t sel_c;
    way_onehot_t invalid;
    way_onehot_t victim_c;
    way_onehot_t repl_victim;
    logic        hit_c;
    logic        multi_c;
    logic        accept;

    logic        rsp_valid_reg;
    logic        hit_reg;
    way_onehot_t way_sel_reg;
    way_onehot_t victim_reg;
    logic        multi_hit_reg;

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_cmp
        assign match[gi] = bus.i_way_valid[gi]
                           && (bus.i_tags[gi*TAG_BITS +: TAG_BITS] == bus.i_req_tag);
    end

    assign hit_c   = |match;
    assign sel_c   = lowest_set(match);
    assign multi_c = (match & (match - way_onehot_t'(1))) != '0;

    // An empty way is always preferred over evicting live data.
    assign invalid  = ~bus.i_way_valid;
    assign victim_c = (|invalid) ? lowest_set(invalid) : repl_victim;

    assign bus.o_req_ready = !rsp_valid_reg || bus.i_rsp_ready;
    assign accept          = bus.i_req_valid && bus.o_req_ready;

`ifdef WAY_HIT_PLRU_EN
    plru_tree u_plru (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .rd_set    (bus.i_req_set),
        .rd_victim (repl_victim),
        .hit_en    (accept && hit_c),
        .hit_set   (bus.i_req_set),
        .hit_way   (sel_c),
        .fill_en   (bus.i_fill_valid),
        .fill_set  (bus.i_fill_set),
        .fill_way  (bus.i_fill_way)
    );
`else
    logic [LVLS-1:0] rr_cnt_reg;
    logic            unused_fill;

    // Wraps naturally because WAYS is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_cnt_reg <= '0;
        end else if (accept && !hit_c) begin
            rr_cnt_reg <= rr_cnt_reg + LVLS'(1);
        end
    end

    assign repl_victim = way_onehot_t'(1) << rr_cnt_reg;
    assign unused_fill = ^{bus.i_fill_valid, bus.i_fill_set, bus.i_fill_way, bus.i_req_set};
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp_valid_reg <= 1'b0;
            hit_reg       <= 1'b0;
            way_sel_reg   <= '0;
            victim_reg    <= '0;
            multi_hit_reg <= 1'b0;
        end else if (accept) begin
            rsp_valid_reg <= 1'b1;
            hit_reg       <= hit_c;
            way_sel_reg   <= sel_c;
            victim_reg    <= victim_c;
            multi_hit_reg <= multi_c;
        end else if (bus.i_rsp_ready) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    assign bus.o_rsp_valid  = rsp_valid_reg;
    assign bus.o_hit        = hit_reg;
    assign bus.o_way_sel    = way_sel_reg;
    assign bus.o_victim_way = victim_reg;
    assign bus.o_multi_hit  = multi_hit_reg;

endmodule

// File: tb/tb_way_hit_detect.sv
// Directed and random stimulus for way_hit_detect checked against a behavioural cache model.
// Follows WAY_HIT_PLRU_EN the same way the design does.
module tb_way_hit_detect;
    import cache_pkg::*;

    logic clk;
    logic rst_n;

    way_hit_detect_if bus ();

    way_hit_detect dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int txns   = 0;

    // Reference state: what the response registers should hold and the replacement history.
    logic        m_rsp_valid;
    logic        m_hit;
    logic        m_multi;
    way_onehot_t m_sel;
    way_onehot_t m_vic;
    int          m_tree [SETS][WAYS-1];
    int          m_rr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_rsp_valid = 1'b0;
        m_hit       = 1'b0;
        m_multi     = 1'b0;
        m_sel       = '0;
        m_vic       = '0;
        m_rr        = 0;
        for (int s = 0; s < SETS; s++)
            for (int n = 0; n < WAYS - 1; n++) m_tree[s][n] = 0;
    endtask

    // Leaves sit at heap positions WAYS-1 .. 2*WAYS-2 in way order.
    function automatic int tree_victim(input int s);
        int n;
        n = 0;
        while (n < WAYS - 1) n = 2 * n + 1 + m_tree[s][n];
        return n - (WAYS - 1);
    endfunction

    // Climb from the leaf; each parent is made to point at the sibling subtree.
    task automatic tree_touch(input int s, input int w);
        int n;
        int p;
        n = w + WAYS - 1;
        while (n > 0) begin
            p = (n - 1) / 2;
            m_tree[s][p] = (n == 2 * p + 1) ? 1 : 0;
            n = p;
        end
    endtask

    task automatic drive(input bit v, input int set, input logic [TAG_BITS-1:0] tag,
                         input logic [TAG_BITS-1:0] t0, input logic [TAG_BITS-1:0] t1,
                         input logic [TAG_BITS-1:0] t2, input logic [TAG_BITS-1:0] t3,
                         input way_onehot_t wv);
        bus.i_req_valid = v;
        bus.i_req_set   = SET_BITS'(set);
        bus.i_req_tag   = tag;
        bus.i_tags      = {t3, t2, t1, t0};
        bus.i_way_valid = wv;
    endtask

    task automatic fill(input bit v, input int set, input way_onehot_t way);
        bus.i_fill_valid = v;
        bus.i_fill_set   = SET_BITS'(set);
        bus.i_fill_way   = way;
    endtask

    task automatic check_outputs();
        check("rsp_valid", 32'(bus.o_rsp_valid), 32'(m_rsp_valid));
        check("hit", 32'(bus.o_hit), 32'(m_hit));
        check("way_sel", 32'(bus.o_way_sel), 32'(m_sel));
        check("victim_way", 32'(bus.o_victim_way), 32'(m_vic));
        check("multi_hit", 32'(bus.o_multi_hit), 32'(m_multi));
    endtask

    // One clock: check ready, advance the model with the driven inputs, then check outputs.
    task automatic cycle();
        logic        exp_ready;
        logic        acc;
        logic        fill_ok;
        int          cnt;
        int          sel_idx;
        int          fill_idx;
        int          rset;
        way_onehot_t sel;
        way_onehot_t vic;

        #1;
        exp_ready = !m_rsp_valid || bus.i_rsp_ready;
        check("req_ready", 32'(bus.o_req_ready), 32'(exp_ready));
        acc  = bus.i_req_valid && exp_ready;
        rset = int'(bus.i_req_set);

        cnt = 0; sel = '0; sel_idx = 0;
        for (int i = 0; i < WAYS; i++) begin
            if (bus.i_way_valid[i] && bus.i_tags[i*TAG_BITS +: TAG_BITS] == bus.i_req_tag) begin
                if (cnt == 0) begin
                    sel[i]  = 1'b1;
                    sel_idx = i;
                end
                cnt++;
            end
        end

        vic = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!bus.i_way_valid[i]) begin
                vic    = '0;
                vic[i] = 1'b1;
            end
        end
`ifdef WAY_HIT_PLRU_EN
        if (vic == '0) vic[tree_victim(rset)] = 1'b1;
`else
        if (vic == '0) vic[m_rr] = 1'b1;
`endif

        fill_ok  = bus.i_fill_valid && ($countones(bus.i_fill_way) == 1);
        fill_idx = 0;
        for (int i = 0; i < WAYS; i++) if (bus.i_fill_way[i]) fill_idx = i;

`ifdef WAY_HIT_PLRU_EN
        if (fill_ok) tree_touch(int'(bus.i_fill_set), fill_idx);
        if (acc && cnt > 0 && !(fill_ok && bus.i_fill_set == bus.i_req_set))
            tree_touch(rset, sel_idx);
`else
        if (acc && cnt == 0) m_rr = (m_rr + 1) % WAYS;
`endif

        if (acc) begin
            m_rsp_valid = 1'b1;
            m_hit       = (cnt > 0);
            m_multi     = (cnt > 1);
            m_sel       = sel;
            m_vic       = vic;
            txns++;
            $display("txn %0d: set=%0d tag=%05h valid=%b -> hit=%b sel=%b victim=%b multi=%b",
                     txns, rset, bus.i_req_tag, bus.i_way_valid, m_hit, m_sel, m_vic, m_multi);
        end else if (bus.i_rsp_ready) begin
            m_rsp_valid = 1'b0;
        end

        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_rsp_ready = 1'b0;
        drive(0, 0, '0, '0, '0, '0, '0, '0);
        fill(0, 0, '0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        check("reset_ready", 32'(bus.o_req_ready), 32'd1);
        rst_n = 1'b1;
        bus.i_rsp_ready = 1'b1;

        // All ways valid, no tag match.
        drive(1, 0, 20'h12345, 20'h00001, 20'h00002, 20'h00003, 20'h00004, 4'b1111);
        cycle();
        check("first_miss_victim", 32'(bus.o_victim_way), 32'b0001);
        check("first_miss_sel", 32'(bus.o_way_sel), 32'b0000);

        // Set 5: hit way 0, then miss, then hit way 2, then miss.
        drive(1, 5, 20'hABCDE, 20'hABCDE, 20'h11111, 20'h22222, 20'h33333, 4'b1111);
        cycle();
        check("set5_hit_sel", 32'(bus.o_way_sel), 32'b0001);
        drive(1, 5, 20'h55555, 20'hABCDE, 20'h11111, 20'h22222, 20'h33333, 4'b1111);
        cycle();
`ifdef WAY_HIT_PLRU_EN
        check("set5_victim_after_w0", 32'(bus.o_victim_way), 32'b0100);
`endif
        drive(1, 5, 20'h22222, 20'hABCDE, 20'h11111, 20'h22222, 20'h33333, 4'b1111);
        cycle();
        check("set5_hit_w2", 32'(bus.o_way_sel), 32'b0100);
        drive(1, 5, 20'h55555, 20'hABCDE, 20'h11111, 20'h22222, 20'h33333, 4'b1111);
        cycle();
`ifdef WAY_HIT_PLRU_EN
        check("set5_victim_after_w2", 32'(bus.o_victim_way), 32'b0010);
`endif

        // Invalid way beats the replacement policy.
        drive(1, 5, 20'h55555, 20'hABCDE, 20'h11111, 20'h22222, 20'h33333, 4'b1011);
        cycle();
        check("invalid_victim", 32'(bus.o_victim_way), 32'b0100);

        // Two matching ways.
        drive(1, 3, 20'h77777, 20'h00000, 20'h77777, 20'h11111, 20'h77777, 4'b1111);
        cycle();
        check("multi_sel", 32'(bus.o_way_sel), 32'b0010);
        check("multi_flag", 32'(bus.o_multi_hit), 32'd1);

        // Backpressure: response held for three cycles, then released.
        drive(1, 9, 20'hAAAAA, 20'h00000, 20'hAAAAA, 20'h11111, 20'h22222, 4'b1111);
        cycle();
        bus.i_rsp_ready = 1'b0;
        drive(1, 9, 20'hBBBBB, 20'h00000, 20'h11111, 20'hBBBBB, 20'h22222, 4'b1111);
        repeat (3) begin
            cycle();
            check("stall_ready", 32'(bus.o_req_ready), 32'd0);
            check("stall_sel", 32'(bus.o_way_sel), 32'b0010);
        end
        bus.i_rsp_ready = 1'b1;
        cycle();
        check("release_sel", 32'(bus.o_way_sel), 32'b0100);

        // Same-set hit and fill in one cycle: only the fill touch counts.
        drive(1, 7, 20'hCCCCC, 20'hCCCCC, 20'h11111, 20'h22222, 20'h33333, 4'b1111);
        fill(1, 7, 4'b1000);
        cycle();
        fill(0, 0, '0);
        drive(1, 7, 20'h99999, 20'hCCCCC, 20'h11111, 20'h22222, 20'h33333, 4'b1111);
        cycle();
`ifdef WAY_HIT_PLRU_EN
        check("set7_fill_priority", 32'(bus.o_victim_way), 32'b0001);
`endif

        // Random traffic over a few sets and a small tag pool so hits and multi-hits occur.
        for (int k = 0; k < 400; k++) begin
            logic [TAG_BITS-1:0] t [WAYS];
            way_onehot_t         wv;
            way_onehot_t         fw;
            for (int i = 0; i < WAYS; i++) t[i] = TAG_BITS'(32'h10 + $urandom_range(0, 3));
            wv = ($urandom_range(0, 1) == 1) ? 4'b1111 : way_onehot_t'($urandom_range(0, 15));
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3),
                  TAG_BITS'(32'h10 + $urandom_range(0, 4)), t[0], t[1], t[2], t[3], wv);
            bus.i_rsp_ready = ($urandom_range(0, 3) != 0);
            fw = ($urandom_range(0, 3) == 0) ? way_onehot_t'($urandom_range(0, 15))
                                             : way_onehot_t'(1) << $urandom_range(0, WAYS - 1);
            fill($urandom_range(0, 3) == 0, $urandom_range(0, 3), fw);
            cycle();
        end

        // Asynchronous reset in mid-cycle drops a pending request.
        bus.i_rsp_ready = 1'b1;
        fill(0, 0, '0);
        drive(1, 2, 20'h11111, 20'h11111, 20'h11111, 20'h22222, 20'h33333, 4'b1111);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
        drive(0, 0, '0, '0, '0, '0, '0, '0);
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
